// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the master transmitter and the slave receiver.
package spi_pkg;
   typedef enum logic [2:0] {IDLE, LEAD, LOW, HIGH, TRAIL, GAP} tx_state_t;

   localparam int   CPOL             = 1;
   localparam int   CPHA             = 1;
   localparam logic IDLE_VAL_DEFAULT = 1'b1;
endpackage

// File: rtl/spi_bus.sv
// Three-wire SPI link (no miso) between spi_master_transmitter and spi_slave_receiver.
interface spi_bus;
   logic sclk;
   logic cs_n;
   logic mosi;

   modport master (output sclk, output cs_n, output mosi);
   modport slave  (input  sclk, input  cs_n, input  mosi);
endinterface

// File: rtl/spi_clk_div.sv
// Half-period tick for sclk: counts 0..CLK_DIV-1 and wraps; restart holds it at zero.
module spi_clk_div #(
   parameter int CLK_DIV = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       restart,
   output logic [$clog2(CLK_DIV)-1:0] cnt,
   output logic                       tc
);
   localparam int CNT_W = $clog2(CLK_DIV);

   assign tc = (cnt == CNT_W'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            cnt <= '0;
      else if (restart || tc) cnt <= '0;
      else                   cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/spi_master_transmitter.sv
// Mode 3 SPI master: serialises valid/ready words MSB first, back-to-back words share one cs_n frame.
module spi_master_transmitter
   import spi_pkg::*;
#(
   parameter int   DATA_WIDTH = 8,
   parameter int   CLK_DIV    = 4,
   parameter logic IDLE_VAL   = IDLE_VAL_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_in_valid,
   output logic                  data_in_ready,
   spi_bus.master                spi_bus_0
);
   localparam int BIT_W = $clog2(DATA_WIDTH);
   localparam int DIV_W = $clog2(CLK_DIV);

   if (DATA_WIDTH < 2 || CLK_DIV < 2 || CPOL != 1 || CPHA != 1) begin : g_bad_cfg
      $error("spi_master_transmitter: unsupported configuration");
   end

   tx_state_t             state, state_nxt;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic                  sclk_q, sclk_d;
   logic                  cs_q, cs_d;
   logic                  mosi_q, mosi_d;
   logic                  ready_q, ready_d;
   logic [DIV_W-1:0]      div_cnt;
   logic                  tc;
   logic                  accept, last_bit, pre_ready;

   spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (state == IDLE),
      .cnt     (div_cnt),
      .tc      (tc)
   );

   assign accept    = data_in_valid && ready_q;
   assign last_bit  = (bit_q == BIT_W'(DATA_WIDTH - 1));
   // Ready is registered, so it is raised one cycle early to land on the final HIGH cycle.
   assign pre_ready = (state == HIGH) && last_bit && (div_cnt == DIV_W'(CLK_DIV - 2));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = LEAD;
         LEAD:    if (tc)     state_nxt = LOW;
         LOW:     if (tc)     state_nxt = HIGH;
         HIGH:    if (tc)     state_nxt = (!last_bit || accept) ? LOW : TRAIL;
         TRAIL:   if (tc)     state_nxt = GAP;
         GAP:     if (tc)     state_nxt = IDLE;
         default:             state_nxt = IDLE;
      endcase
   end

   always_comb begin
      shift_d = shift_q;
      bit_d   = bit_q;
      sclk_d  = sclk_q;
      cs_d    = cs_q;
      mosi_d  = mosi_q;
      ready_d = (state_nxt == IDLE) || pre_ready;
      unique case (state)
         IDLE: if (accept) begin
            shift_d = data_in;
            bit_d   = '0;
            cs_d    = 1'b0;
            sclk_d  = 1'b1;
            mosi_d  = data_in[DATA_WIDTH-1];
         end
         LEAD: if (tc) sclk_d = 1'b0;
         LOW:  if (tc) sclk_d = 1'b1;
         HIGH: if (tc) begin
            if (!last_bit) begin
               bit_d   = bit_q + 1'b1;
               shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
               mosi_d  = shift_q[DATA_WIDTH-2];
               sclk_d  = 1'b0;
            end else if (accept) begin
               shift_d = data_in;
               bit_d   = '0;
               mosi_d  = data_in[DATA_WIDTH-1];
               sclk_d  = 1'b0;
            end
         end
         TRAIL: if (tc) begin
            cs_d   = 1'b1;
            mosi_d = IDLE_VAL;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         bit_q   <= '0;
         sclk_q  <= 1'(CPOL);
         cs_q    <= 1'b1;
         mosi_q  <= IDLE_VAL;
         ready_q <= 1'b0;
      end else begin
         shift_q <= shift_d;
         bit_q   <= bit_d;
         sclk_q  <= sclk_d;
         cs_q    <= cs_d;
         mosi_q  <= mosi_d;
         ready_q <= ready_d;
      end
   end

   assign spi_bus_0.sclk = sclk_q;
   assign spi_bus_0.cs_n = cs_q;
   assign spi_bus_0.mosi = mosi_q;
   assign data_in_ready  = ready_q;
endmodule

// File: tb/tb_spi_master_transmitter.sv
// Bench for spi_master_transmitter: default config (dut 0) and 16-bit / CLK_DIV=2 (dut 1).
module tb_spi_master_transmitter;
   logic        clk;
   logic        rst_n;
   logic [7:0]  din0;
   logic [15:0] din1;
   logic        vld0, vld1, rdy0, rdy1;
   logic [15:0] wq[$];
   int          vectors, miscompares;

   spi_bus bus0();
   spi_bus bus1();

   spi_master_transmitter u_dut0 (
      .clk(clk), .rst_n(rst_n), .data_in(din0), .data_in_valid(vld0),
      .data_in_ready(rdy0), .spi_bus_0(bus0)
   );

   spi_master_transmitter #(.DATA_WIDTH(16), .CLK_DIV(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .data_in(din1), .data_in_valid(vld1),
      .data_in_ready(rdy1), .spi_bus_0(bus1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic g_cs(input int d);   return d ? bus1.cs_n : bus0.cs_n; endfunction
   function automatic logic g_sclk(input int d); return d ? bus1.sclk : bus0.sclk; endfunction
   function automatic logic g_mosi(input int d); return d ? bus1.mosi : bus0.mosi; endfunction
   function automatic logic g_rdy(input int d);  return d ? rdy1 : rdy0;           endfunction

   task automatic drive(input int d, input logic v, input logic [15:0] w);
      if (d != 0) begin din1 = w;      vld1 = v; end
      else        begin din0 = w[7:0]; vld0 = v; end
   endtask

   // Sends wq on dut d (burst: valid held; otherwise next word raised once cs_n rises)
   // and checks the observed frames against the frame-level rules.
   task automatic run(input int d, input int burst);
      int dw, cd, n, idx, acc, exp_fr, per;
      int len, rise, low, lead, rdy, gap, gap_left, gap_bad, mosi_bad;
      logic fell, cs, sc, mo, rd, cs_p, sc_p, rd_p, v, done;
      logic bitq[$];
      int fl[$], fr[$], fo[$], fe[$], fy[$], gq[$];
      dw = (d != 0) ? 16 : 8;
      cd = (d != 0) ? 2 : 4;
      n  = wq.size();
      exp_fr = (burst != 0) ? 1 : n;
      per    = (burst != 0) ? n : 1;
      idx = 0; acc = 0; gap = 0; gap_left = 0; gap_bad = 0; mosi_bad = 0;
      len = 0; rise = 0; low = 0; lead = 0; rdy = 0; fell = 0; done = 0;
      @(negedge clk);
      cs_p = g_cs(d); sc_p = g_sclk(d); rd_p = g_rdy(d);
      check("idle_cs", cs_p, 1);
      drive(d, 1'b1, wq[0]);
      v = 1'b1;
      for (int cyc = 0; cyc < 6000; cyc++) begin
         @(negedge clk);
         cs = g_cs(d); sc = g_sclk(d); mo = g_mosi(d); rd = g_rdy(d);
         if (v && rd_p) begin
            acc++; idx++;
            if (burst != 0 && idx < n) drive(d, 1'b1, wq[idx]);
            else begin drive(d, 1'b0, 16'h0); v = 1'b0; end
         end
         if (!cs) begin
            if (cs_p) begin
               len = 0; rise = 0; low = 0; lead = 0; rdy = 0; fell = 0;
               if (fl.size() > 0) gq.push_back(gap);
            end
            len++;
            if (!sc) begin low++; fell = 1'b1; end
            else if (!fell) lead++;
            if (sc && !sc_p) begin rise++; bitq.push_back(mo); end
            if (rd) rdy++;
         end else begin
            if (!cs_p) begin
               fl.push_back(len); fr.push_back(rise); fo.push_back(low);
               fe.push_back(lead); fy.push_back(rdy);
               gap = 0; gap_left = cd;
               if (burst == 0 && idx < n && !v) begin drive(d, 1'b1, wq[idx]); v = 1'b1; end
            end
            gap++;
            if (gap_left > 0) begin
               if (rd) gap_bad++;
               gap_left--;
            end
            if (mo !== 1'b1) mosi_bad++;
            if (acc == n && fl.size() == exp_fr) begin done = 1'b1; break; end
         end
         cs_p = cs; sc_p = sc; rd_p = rd;
      end
      drive(d, 1'b0, 16'h0);
      if (!done) check("timeout", 0, 1);
      check("accepts", acc, n);
      check("frames", fl.size(), exp_fr);
      for (int i = 0; i < fl.size(); i++) begin
         check("cs_low_len", fl[i], cd * (2 * dw * per + 2));
         check("sclk_rises", fr[i], dw * per);
         check("sclk_low",   fo[i], cd * dw * per);
         check("lead",       fe[i], cd);
         check("ready_in_frame", fy[i], per);
      end
      foreach (gq[i]) check("gap_min", (gq[i] >= cd) ? 1 : 0, 1);
      check("ready_in_gap", gap_bad, 0);
      check("mosi_idle", mosi_bad, 0);
      for (int i = 0; i < n; i++) begin
         logic [15:0] x, m;
         x = '0;
         for (int b = 0; b < dw; b++)
            x = {x[14:0], (i * dw + b < bitq.size()) ? bitq[i * dw + b] : 1'b0};
         m = (d != 0) ? 16'hFFFF : 16'h00FF;
         check("word", x, wq[i] & m);
      end
   endtask

   initial begin
      logic sc, sc_p, rd_p;
      int   rises;
      vectors = 0; miscompares = 0;
      rst_n = 1'b0; din0 = '0; din1 = '0; vld0 = 1'b0; vld1 = 1'b0;

      // Reset and idle
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rst_sclk0", bus0.sclk, 1); check("rst_cs0", bus0.cs_n, 1);
         check("rst_mosi0", bus0.mosi, 1); check("rst_rdy0", rdy0, 0);
         check("rst_sclk1", bus1.sclk, 1); check("rst_cs1", bus1.cs_n, 1);
         check("rst_rdy1", rdy1, 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("rdy_after_rst0", rdy0, 1);
      check("rdy_after_rst1", rdy1, 1);

      // Single word, burst, backpressure (valid raised during GAP)
      wq = {}; wq.push_back(16'h00A5); run(0, 0);
      wq = {}; wq.push_back(16'h003C); wq.push_back(16'h00FF); run(0, 1);
      wq = {}; wq.push_back(16'h005A); wq.push_back(16'h00C3); run(0, 0);

      // Reset in the middle of 8'h81
      @(negedge clk);
      drive(0, 1'b1, 16'h0081);
      rd_p = rdy0; sc_p = bus0.sclk; rises = 0;
      for (int cyc = 0; cyc < 500 && rises < 3; cyc++) begin
         @(negedge clk);
         if (vld0 && rd_p) drive(0, 1'b0, 16'h0);
         sc = bus0.sclk;
         if (!bus0.cs_n && sc && !sc_p) rises++;
         sc_p = sc; rd_p = rdy0;
      end
      check("midword_reached", rises, 3);
      #3 rst_n = 1'b0;
      #1;
      check("midrst_cs", bus0.cs_n, 1);
      check("midrst_sclk", bus0.sclk, 1);
      check("midrst_mosi", bus0.mosi, 1);
      check("midrst_rdy", rdy0, 0);
      drive(0, 1'b0, 16'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      wq = {}; wq.push_back(16'h007E); run(0, 0);

      // Wide word on the 16-bit / CLK_DIV=2 instance
      wq = {}; wq.push_back(16'hBEEF); run(1, 0);

      // Randomized traffic on both instances
      for (int r = 0; r < 12; r++) begin
         int d, b, n;
         d = int'($urandom_range(0, 1));
         b = int'($urandom_range(0, 1));
         n = int'($urandom_range(1, 3));
         wq = {};
         for (int i = 0; i < n; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if (d == 0) w[15:8] = 8'h00;
            wq.push_back(w);
         end
         run(d, b);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
